trig_type_lv1b_multi: RTL and testbench

Parametrised successor of the single-type LV1B trigger-type block. It evaluates N_TYPE independent LV1B trigger types in parallel against the same LV1A/LV1B-request/cluster-count inputs. Each type has its own cluster-multiplicity mask, enable and p-of-q prescaler. It produces per-type raw and prescaled triggers, saturating raw/scaled counters, and a prioritised type ID for the downstream LV1B issuer in the top CDT.

---
 rtl/trig_type_lv1b_multi.sv | 120 ++++++++++++
 tb/tb_trig_type_lv1b_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/trig_type_lv1b_multi.sv
// Parallel LV1B trigger-type evaluation: per-type cluster mask, enable, p-of-q prescaler and saturating counters.
// Latency 1 cycle (all outputs registered); no backpressure, every qualifying cycle is evaluated.
module trig_type_lv1b_multi #(
    parameter int N_TYPE     = 4,
    parameter int NCLUS_W    = 4,
    parameter int NCLUS_MAX  = 9,
    parameter int PRESCALE_W = 16,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_live,
    input  logic                         in_ena,
    input  logic                         in_lv1a,
    input  logic                         in_lv1b_req,
    input  logic [NCLUS_W-1:0]           in_nclus,
    input  logic [N_TYPE*(NCLUS_MAX+1)-1:0] user_nclus,
    input  logic [N_TYPE*PRESCALE_W-1:0] user_prescale_p,
    input  logic [N_TYPE*PRESCALE_W-1:0] user_prescale_q,
    input  logic [N_TYPE-1:0]            user_ena,
    output logic [N_TYPE-1:0]            out_lv1b_raw,
    output logic [N_TYPE-1:0]            out_lv1b_scaled,
    output logic                         out_any_scaled,
    output logic [3:0]                   out_type_id,
    output logic [N_TYPE*CNT_W-1:0]      raw_cnt,
    output logic [N_TYPE*CNT_W-1:0]      scaled_cnt
);

    localparam int NCLUS_TOT = NCLUS_MAX + 1;
    localparam int IDX_W     = (NCLUS_TOT < 2) ? 1 : $clog2(NCLUS_TOT);

    logic                                r_pre_live;
    logic [N_TYPE-1:0][PRESCALE_W-1:0]   r_pcnt;
    logic [N_TYPE-1:0][CNT_W-1:0]        r_raw_cnt;
    logic [N_TYPE-1:0][CNT_W-1:0]        r_scl_cnt;
    logic [N_TYPE-1:0]                   r_raw;
    logic [N_TYPE-1:0]                   r_scaled;
    logic                                r_any;
    logic [3:0]                          r_type_id;

    logic                                w_run_start;
    logic [IDX_W-1:0]                    w_idx;
    logic [N_TYPE-1:0]                   w_qual;
    logic [N_TYPE-1:0]                   w_scaled;
    logic [N_TYPE-1:0][PRESCALE_W-1:0]   w_pcnt_nxt;
    logic [N_TYPE-1:0][CNT_W-1:0]        w_raw_nxt;
    logic [N_TYPE-1:0][CNT_W-1:0]        w_scl_nxt;
    logic [3:0]                          w_type_id;

    assign w_run_start = in_live & ~r_pre_live;
    assign w_idx       = (in_nclus > NCLUS_W'(NCLUS_MAX)) ? IDX_W'(NCLUS_MAX) : IDX_W'(in_nclus);

    for (genvar g = 0; g < N_TYPE; g++) begin : g_type
        logic [NCLUS_TOT-1:0]  w_mask;
        logic [PRESCALE_W-1:0] w_p;
        logic [PRESCALE_W-1:0] w_q;
        logic [PRESCALE_W-1:0] w_q_eff;
        logic [PRESCALE_W-1:0] w_pcnt_cur;
        logic [CNT_W-1:0]      w_raw_cur;
        logic [CNT_W-1:0]      w_scl_cur;

        assign w_mask  = user_nclus[g*NCLUS_TOT +: NCLUS_TOT];
        assign w_p     = user_prescale_p[g*PRESCALE_W +: PRESCALE_W];
        assign w_q     = user_prescale_q[g*PRESCALE_W +: PRESCALE_W];
        assign w_q_eff = (w_q == '0) ? PRESCALE_W'(1) : w_q;

        // A run start zeroes state before this cycle's trigger is evaluated.
        assign w_pcnt_cur = w_run_start ? '0 : r_pcnt[g];
        assign w_raw_cur  = w_run_start ? '0 : r_raw_cnt[g];
        assign w_scl_cur  = w_run_start ? '0 : r_scl_cnt[g];

        assign w_qual[g]   = in_ena & user_ena[g] & in_lv1b_req & in_lv1a & w_mask[w_idx];
        assign w_scaled[g] = w_qual[g] & (w_pcnt_cur < w_p);

        // ">=" rather than "==" so a q shrunk mid-run wraps instead of running away.
        assign w_pcnt_nxt[g] = !w_qual[g] ? w_pcnt_cur :
                               (w_pcnt_cur >= w_q_eff - PRESCALE_W'(1)) ? '0 :
                               w_pcnt_cur + PRESCALE_W'(1);

        assign w_raw_nxt[g] = (!w_qual[g] || w_raw_cur == '1) ? w_raw_cur : w_raw_cur + CNT_W'(1);
        assign w_scl_nxt[g] = (!w_scaled[g] || w_scl_cur == '1) ? w_scl_cur : w_scl_cur + CNT_W'(1);
    end

    always_comb begin
        w_type_id = '0;
        for (int i = N_TYPE - 1; i >= 0; i--) begin
            if (w_scaled[i]) w_type_id = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre_live <= 1'b0;
            r_pcnt     <= '0;
            r_raw_cnt  <= '0;
            r_scl_cnt  <= '0;
            r_raw      <= '0;
            r_scaled   <= '0;
            r_any      <= 1'b0;
            r_type_id  <= '0;
        end else begin
            r_pre_live <= in_live;
            r_pcnt     <= w_pcnt_nxt;
            r_raw_cnt  <= w_raw_nxt;
            r_scl_cnt  <= w_scl_nxt;
            r_raw      <= w_qual;
            r_scaled   <= w_scaled;
            r_any      <= |w_scaled;
            r_type_id  <= w_type_id;
        end
    end

    assign out_lv1b_raw    = r_raw;
    assign out_lv1b_scaled = r_scaled;
    assign out_any_scaled  = r_any;
    assign out_type_id     = r_type_id;
    assign raw_cnt         = r_raw_cnt;
    assign scaled_cnt      = r_scl_cnt;

endmodule

// File: tb/tb_trig_type_lv1b_multi.sv
// Bench for trig_type_lv1b_multi: directed stimulus, cycle-by-cycle model comparison plus literal expectations.
module tb_trig_type_lv1b_multi;
    localparam int N    = 4;
    localparam int NW   = 4;
    localparam int NMAX = 9;
    localparam int PW   = 16;
    localparam int CW   = 4;
    localparam int MT   = NMAX + 1;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, in_live, in_ena, in_lv1a, in_lv1b_req;
    logic [NW-1:0]     in_nclus;
    logic [N*MT-1:0]   user_nclus;
    logic [N*PW-1:0]   user_prescale_p, user_prescale_q;
    logic [N-1:0]      user_ena;
    logic [N-1:0]      out_lv1b_raw, out_lv1b_scaled;
    logic              out_any_scaled;
    logic [3:0]        out_type_id;
    logic [N*CW-1:0]   raw_cnt, scaled_cnt;

    trig_type_lv1b_multi #(
        .N_TYPE(N), .NCLUS_W(NW), .NCLUS_MAX(NMAX), .PRESCALE_W(PW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_live(in_live), .in_ena(in_ena),
        .in_lv1a(in_lv1a), .in_lv1b_req(in_lv1b_req), .in_nclus(in_nclus),
        .user_nclus(user_nclus), .user_prescale_p(user_prescale_p),
        .user_prescale_q(user_prescale_q), .user_ena(user_ena),
        .out_lv1b_raw(out_lv1b_raw), .out_lv1b_scaled(out_lv1b_scaled),
        .out_any_scaled(out_any_scaled), .out_type_id(out_type_id),
        .raw_cnt(raw_cnt), .scaled_cnt(scaled_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Model: each type remembers how many triggers it has seen in the current period.
    int       m_pos[N], m_rc[N], m_sc[N];
    bit       m_pre;
    bit [N-1:0] m_raw, m_scl;
    bit       m_any;
    int       m_id;
    int       m_idx, m_p, m_per;
    bit       m_start, m_hit;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pre = 0; m_raw = '0; m_scl = '0; m_any = 0; m_id = 0;
            for (int i = 0; i < N; i++) begin m_pos[i] = 0; m_rc[i] = 0; m_sc[i] = 0; end
        end else begin
            m_idx   = (int'(in_nclus) > NMAX) ? NMAX : int'(in_nclus);
            m_start = in_live && !m_pre;
            m_pre   = in_live;
            m_any   = 0;
            m_id    = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (m_start) begin m_pos[i] = 0; m_rc[i] = 0; m_sc[i] = 0; end
                m_p   = int'(user_prescale_p[i*PW +: PW]);
                m_per = (user_prescale_q[i*PW +: PW] == 0) ? 1 : int'(user_prescale_q[i*PW +: PW]);
                m_hit = in_ena && user_ena[i] && in_lv1a && in_lv1b_req && user_nclus[i*MT + m_idx];
                m_raw[i] = m_hit;
                m_scl[i] = m_hit && (m_pos[i] < m_p);
                if (m_hit) m_pos[i] = (m_pos[i] + 1 >= m_per) ? 0 : m_pos[i] + 1;
                if (m_hit && m_rc[i] < CMAX) m_rc[i] = m_rc[i] + 1;
                if (m_scl[i] && m_sc[i] < CMAX) m_sc[i] = m_sc[i] + 1;
                if (m_scl[i]) begin m_any = 1; m_id = i; end
            end
        end
        #1;
        chk("raw", out_lv1b_raw, m_raw);
        chk("scaled", out_lv1b_scaled, m_scl);
        chk("any_scaled", out_any_scaled, m_any);
        chk("type_id", out_type_id, m_id);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("raw_cnt%0d", i), raw_cnt[i*CW +: CW], m_rc[i]);
            chk($sformatf("scaled_cnt%0d", i), scaled_cnt[i*CW +: CW], m_sc[i]);
        end
    end

    task automatic set_type(input int i, input int mask, input int p, input int q, input logic en);
        user_nclus[i*MT +: MT]      = MT'(mask);
        user_prescale_p[i*PW +: PW] = PW'(p);
        user_prescale_q[i*PW +: PW] = PW'(q);
        user_ena[i]                 = en;
    endtask

    // One trigger cycle; returns at the negedge where its registered result is visible.
    task automatic pulse();
        @(negedge clk);
        in_lv1a = 1'b1; in_lv1b_req = 1'b1;
        @(negedge clk);
        in_lv1a = 1'b0; in_lv1b_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    logic [9:0] pat;

    initial begin
        rst_n = 1'b0; in_live = 1'b0; in_ena = 1'b1; in_lv1a = 1'b1; in_lv1b_req = 1'b1;
        in_nclus = 4'd3;
        user_nclus = '0; user_prescale_p = '0; user_prescale_q = '0; user_ena = '0;
        set_type(0, 1 << 3, 1, 1, 1'b1);

        // Reset held while a trigger is asserted
        repeat (3) @(negedge clk);
        chk("reset_raw", out_lv1b_raw, 0);
        chk("reset_raw_cnt0", raw_cnt[0 +: CW], 0);
        rst_n = 1'b1;
        @(negedge clk);
        in_lv1a = 1'b0; in_lv1b_req = 1'b0;
        chk("first_raw0", out_lv1b_raw[0], 1);
        chk("first_raw_cnt0", raw_cnt[0 +: CW], 1);

        // p=2, q=5 pattern
        do_reset();
        set_type(0, 1 << 3, 2, 5, 1'b1);
        pat = 10'b0001100011;
        for (int k = 0; k < 10; k++) begin
            pulse();
            chk($sformatf("pattern%0d", k), out_lv1b_scaled[0], pat[k]);
        end
        chk("pattern_raw_cnt0", raw_cnt[0 +: CW], 10);
        chk("pattern_scaled_cnt0", scaled_cnt[0 +: CW], 4);

        // Cluster clamp
        set_type(0, 1 << 9, 1, 1, 1'b1);
        in_nclus = 4'd15;
        pulse();
        chk("clamp_hit", out_lv1b_raw[0], 1);
        set_type(0, 1 << 3, 1, 1, 1'b1);
        pulse();
        chk("clamp_miss", out_lv1b_raw[0], 0);
        in_nclus = 4'd3;

        // q=0 passes everything at p=1
        set_type(0, 1 << 3, 1, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            pulse();
            chk($sformatf("q0_scaled%0d", k), out_lv1b_scaled[0], 1);
        end

        // p=0 blocks everything
        set_type(0, 1 << 3, 1, 0, 1'b0);
        set_type(2, 1 << 3, 0, 4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            pulse();
            chk($sformatf("p0_raw%0d", k), out_lv1b_raw[2], 1);
            chk($sformatf("p0_scaled%0d", k), out_lv1b_scaled[2], 0);
        end
        chk("p0_raw_cnt2", raw_cnt[2*CW +: CW], 4);
        chk("p0_scaled_cnt2", scaled_cnt[2*CW +: CW], 0);

        // Priority between simultaneous types
        set_type(2, 1 << 3, 0, 4, 1'b0);
        set_type(1, 1 << 3, 1, 1, 1'b1);
        set_type(3, 1 << 3, 1, 1, 1'b1);
        pulse();
        chk("prio_id_1", out_type_id, 1);
        chk("prio_any_1", out_any_scaled, 1);
        user_ena[1] = 1'b0;
        pulse();
        chk("prio_id_3", out_type_id, 3);
        chk("prio_any_3", out_any_scaled, 1);

        // Run start coincident with a trigger
        do_reset();
        set_type(1, 1 << 3, 1, 1, 1'b0);
        set_type(3, 1 << 3, 1, 1, 1'b0);
        set_type(0, 1 << 3, 1, 3, 1'b1);
        repeat (7) pulse();
        chk("prelive_raw_cnt0", raw_cnt[0 +: CW], 7);
        chk("prelive_scaled_cnt0", scaled_cnt[0 +: CW], 3);
        @(negedge clk);
        in_live = 1'b1; in_lv1a = 1'b1; in_lv1b_req = 1'b1;
        @(negedge clk);
        in_lv1a = 1'b0; in_lv1b_req = 1'b0;
        chk("live_raw_cnt0", raw_cnt[0 +: CW], 1);
        chk("live_scaled0", out_lv1b_scaled[0], 1);
        chk("live_scaled_cnt0", scaled_cnt[0 +: CW], 1);

        // Saturation at all-ones
        repeat (13) pulse();
        chk("sat_pre_raw_cnt0", raw_cnt[0 +: CW], CMAX - 1);
        for (int k = 0; k < 3; k++) begin
            pulse();
            chk($sformatf("sat_raw_cnt0_%0d", k), raw_cnt[0 +: CW], CMAX);
        end

        in_live = 1'b0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
